// File: rtl/matrix_scan_driver.sv
// matrix_scan_driver: double-buffered column-scan LED matrix driver with inter-column blanking
module matrix_scan_driver #(
    parameter int COLS           = 8,
    parameter int ROWS           = 8,
    parameter int DWELL          = 64,
    parameter int BLANK          = 4,
    parameter bit ROW_ACTIVE_LOW = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic            load_valid,
    input  logic [ROWS-1:0] load_data,
    output logic            load_ready,
    input  logic            load_restart,
    output logic [COLS-1:0] col_out,
    output logic [ROWS-1:0] row_out,
    output logic            frame_start,
    output logic            swap_pulse
);
    localparam int CW = $clog2(COLS);
    localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int NW = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [NW-1:0] DW_LAST = NW'(DWELL - 1);
    localparam logic [NW-1:0] BL_LAST = NW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);
    localparam logic [ROWS-1:0] ROW_OFF = {ROWS{ROW_ACTIVE_LOW}};

    typedef enum logic {S_BLANK, S_DRIVE} state_t;

    state_t          state, state_n;
    logic [NW-1:0]   cnt, cnt_n;
    logic [CW-1:0]   col, col_n, wr_ptr;
    logic            active, active_n, fs_n;
    logic            pending, boundary, swap, xfer;
    logic [ROWS-1:0] disp [COLS];
    logic [ROWS-1:0] wbuf [COLS];
    logic [ROWS-1:0] row_src;

    assign load_ready = rst_n && !pending;
    assign xfer = load_valid && load_ready && !load_restart;
    assign boundary = active && ena && state == S_DRIVE && cnt == DW_LAST && col == C_LAST;
    assign swap = pending && (boundary || !ena);
    // new frame's column 0 may be driven on the very cycle disp is overwritten
    assign row_src = swap ? wbuf[col_n] : disp[col_n];

    always_comb begin
        state_n = state;
        cnt_n = cnt + 1'b1;
        col_n = col;
        active_n = 1'b1;
        fs_n = 1'b0;
        if (!ena) begin
            state_n = S_BLANK;
            cnt_n = '0;
            col_n = '0;
            active_n = 1'b0;
        end else if (!active) begin
            state_n = (BLANK > 0) ? S_BLANK : S_DRIVE;
            cnt_n = '0;
            col_n = '0;
            fs_n = 1'b1;
        end else if (state == S_BLANK) begin
            state_n = (cnt == BL_LAST) ? S_DRIVE : S_BLANK;
            cnt_n = (cnt == BL_LAST) ? '0 : cnt + 1'b1;
        end else if (cnt == DW_LAST) begin
            state_n = (BLANK > 0) ? S_BLANK : S_DRIVE;
            cnt_n = '0;
            col_n = (col == C_LAST) ? '0 : col + 1'b1;
            fs_n = col == C_LAST;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_BLANK;
            cnt <= '0;
            col <= '0;
            active <= 1'b0;
            col_out <= '0;
            row_out <= ROW_OFF;
            frame_start <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            col <= col_n;
            active <= active_n;
            col_out <= (state_n == S_DRIVE) ? (COLS'(1) << col_n) : '0;
            row_out <= ((state_n == S_DRIVE) ? row_src : '0) ^ ROW_OFF;
            frame_start <= fs_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < COLS; i++) begin
                disp[i] <= '0;
                wbuf[i] <= '0;
            end
            wr_ptr <= '0;
            pending <= 1'b0;
            swap_pulse <= 1'b0;
        end else begin
            swap_pulse <= swap;
            if (swap) begin
                for (int i = 0; i < COLS; i++) disp[i] <= wbuf[i];
                pending <= 1'b0;
            end
            if (load_restart) begin
                wr_ptr <= '0;
            end else if (xfer) begin
                wbuf[wr_ptr] <= load_data;
                wr_ptr <= (wr_ptr == C_LAST) ? '0 : wr_ptr + 1'b1;
                if (wr_ptr == C_LAST) pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_matrix_scan_driver.sv
// tb_matrix_scan_driver: directed checks of scan timing, double buffering, ena and reset behaviour
module tb_matrix_scan_driver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, ena, load_valid, load_restart, load_ready, frame_start, swap_pulse;
    logic [7:0] load_data, col_out, row_out;
    logic rst1_n, ena1, lv1, lr1, rdy1, fs1, sp1;
    logic [7:0] ld1, col1, row1;
    int checks = 0;
    int fails = 0;
    int n = 0;

    matrix_scan_driver #(.COLS(8), .ROWS(8), .DWELL(4), .BLANK(1), .ROW_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .load_restart(load_restart), .col_out(col_out), .row_out(row_out),
        .frame_start(frame_start), .swap_pulse(swap_pulse));

    matrix_scan_driver #(.COLS(8), .ROWS(8), .DWELL(4), .BLANK(0), .ROW_ACTIVE_LOW(1'b1)) dut_nb (
        .clk(clk), .rst_n(rst1_n), .ena(ena1), .load_valid(lv1), .load_data(ld1),
        .load_ready(rdy1), .load_restart(lr1), .col_out(col1), .row_out(row1),
        .frame_start(fs1), .swap_pulse(sp1));

    task automatic cyc;
        @(negedge clk);
        n++;
    endtask

    // m = cycle index within a frame of 8 x (1 blank + 4 drive)
    function automatic logic [7:0] exp_col(int m);
        return (m % 5 == 0) ? 8'h00 : 8'(1 << (m / 5));
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; ena = 1'b1; load_valid = 1'b0; load_restart = 1'b0; load_data = 8'h00;
        rst1_n = 1'b0; ena1 = 1'b1; lv1 = 1'b0; lr1 = 1'b0; ld1 = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (col_out !== 8'h00) begin fails++; $display("FAIL reset_col got %h exp 00", col_out); end
        checks++; if (row_out !== 8'h00) begin fails++; $display("FAIL reset_row got %h exp 00", row_out); end
        checks++; if (load_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b exp 0", load_ready); end
        checks++; if (frame_start !== 1'b0) begin fails++; $display("FAIL reset_fs got %b exp 0", frame_start); end
        checks++; if (swap_pulse !== 1'b0) begin fails++; $display("FAIL reset_swap got %b exp 0", swap_pulse); end
        checks++; if (col1 !== 8'h00) begin fails++; $display("FAIL reset_col_nb got %h exp 00", col1); end
        checks++; if (row1 !== 8'hFF) begin fails++; $display("FAIL reset_row_nb got %h exp ff", row1); end
        checks++; if (rdy1 !== 1'b0) begin fails++; $display("FAIL reset_ready_nb got %b exp 0", rdy1); end
        rst_n = 1'b1;
        n = -1;
    endtask

    task automatic test_scan;
        int m;
        for (int i = 0; i < 80; i++) begin
            cyc();
            m = n % 40;
            checks++; if (col_out !== exp_col(m)) begin fails++; $display("FAIL scan_col n=%0d got %h exp %h", n, col_out, exp_col(m)); end
            checks++; if (frame_start !== (m == 0)) begin fails++; $display("FAIL scan_fs n=%0d got %b exp %b", n, frame_start, m == 0); end
            checks++; if (row_out !== 8'h00) begin fails++; $display("FAIL scan_row n=%0d got %h exp 00", n, row_out); end
            checks++; if (swap_pulse !== 1'b0) begin fails++; $display("FAIL scan_swap n=%0d got %b exp 0", n, swap_pulse); end
        end
        checks++; if (load_ready !== 1'b1) begin fails++; $display("FAIL scan_ready got %b exp 1", load_ready); end
    endtask

    task automatic test_load_swap;
        int m;
        logic [7:0] er;
        for (int k = 0; k < 8; k++) begin
            checks++; if (load_ready !== 1'b1) begin fails++; $display("FAIL load_ready k=%0d got %b exp 1", k, load_ready); end
            load_valid = 1'b1;
            load_data = 8'(17 * (k + 1));
            cyc();
        end
        load_data = 8'hEE;
        checks++; if (load_ready !== 1'b0) begin fails++; $display("FAIL load_full got %b exp 0", load_ready); end
        while (n < 119) begin
            cyc();
            checks++; if (swap_pulse !== 1'b0) begin fails++; $display("FAIL early_swap n=%0d got %b exp 0", n, swap_pulse); end
            checks++; if (load_ready !== 1'b0) begin fails++; $display("FAIL hold_ready n=%0d got %b exp 0", n, load_ready); end
        end
        load_valid = 1'b0;
        cyc();
        checks++; if (swap_pulse !== 1'b1) begin fails++; $display("FAIL swap_pulse n=%0d got %b exp 1", n, swap_pulse); end
        checks++; if (frame_start !== 1'b1) begin fails++; $display("FAIL swap_fs n=%0d got %b exp 1", n, frame_start); end
        checks++; if (load_ready !== 1'b1) begin fails++; $display("FAIL ready_back got %b exp 1", load_ready); end
        while (n < 159) begin
            cyc();
            m = n % 40;
            er = (m % 5 == 0) ? 8'h00 : 8'(17 * (m / 5 + 1));
            checks++; if (col_out !== exp_col(m)) begin fails++; $display("FAIL frame_col n=%0d got %h exp %h", n, col_out, exp_col(m)); end
            checks++; if (row_out !== er) begin fails++; $display("FAIL frame_row n=%0d got %h exp %h", n, row_out, er); end
            checks++; if (swap_pulse !== 1'b0) begin fails++; $display("FAIL frame_swap n=%0d got %b exp 0", n, swap_pulse); end
        end
    endtask

    task automatic test_restart;
        int m;
        logic [7:0] er;
        for (int k = 0; k < 3; k++) begin
            load_valid = 1'b1;
            load_data = 8'(8'hA0 + k);
            cyc();
        end
        load_restart = 1'b1;
        load_data = 8'hFF;
        cyc();
        load_restart = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++; if (load_ready !== 1'b1) begin fails++; $display("FAIL restart_ready k=%0d got %b exp 1", k, load_ready); end
            load_data = 8'(8'hB0 + k);
            cyc();
        end
        load_valid = 1'b0;
        checks++; if (load_ready !== 1'b0) begin fails++; $display("FAIL restart_full got %b exp 0", load_ready); end
        while (n < 200) cyc();
        checks++; if (swap_pulse !== 1'b1) begin fails++; $display("FAIL restart_swap n=%0d got %b exp 1", n, swap_pulse); end
        while (n < 232) begin
            cyc();
            m = n % 40;
            er = (m % 5 == 0) ? 8'h00 : 8'(8'hB0 + m / 5);
            checks++; if (row_out !== er) begin fails++; $display("FAIL restart_row n=%0d got %h exp %h", n, row_out, er); end
        end
    endtask

    task automatic test_boundary;
        int m;
        logic [7:0] er;
        for (int k = 0; k < 8; k++) begin
            checks++; if (load_ready !== 1'b1) begin fails++; $display("FAIL bnd_ready k=%0d got %b exp 1", k, load_ready); end
            load_valid = 1'b1;
            load_data = 8'(8'hC0 + k);
            cyc();
        end
        load_valid = 1'b0;
        checks++; if (swap_pulse !== 1'b0) begin fails++; $display("FAIL bnd_noswap n=%0d got %b exp 0", n, swap_pulse); end
        checks++; if (frame_start !== 1'b1) begin fails++; $display("FAIL bnd_fs n=%0d got %b exp 1", n, frame_start); end
        checks++; if (load_ready !== 1'b0) begin fails++; $display("FAIL bnd_pending got %b exp 0", load_ready); end
        while (n < 279) begin
            cyc();
            m = n % 40;
            er = (m % 5 == 0) ? 8'h00 : 8'(8'hB0 + m / 5);
            checks++; if (row_out !== er) begin fails++; $display("FAIL bnd_row n=%0d got %h exp %h", n, row_out, er); end
            checks++; if (swap_pulse !== 1'b0) begin fails++; $display("FAIL bnd_swap n=%0d got %b exp 0", n, swap_pulse); end
        end
        cyc();
        checks++; if (swap_pulse !== 1'b1) begin fails++; $display("FAIL bnd_late_swap n=%0d got %b exp 1", n, swap_pulse); end
        cyc();
        checks++; if (col_out !== 8'h01) begin fails++; $display("FAIL bnd_col n=%0d got %h exp 01", n, col_out); end
        checks++; if (row_out !== 8'hC0) begin fails++; $display("FAIL bnd_newrow n=%0d got %h exp c0", n, row_out); end
    endtask

    task automatic test_ena;
        int m;
        logic [7:0] er;
        for (int k = 0; k < 8; k++) begin
            load_valid = 1'b1;
            load_data = 8'(8'hD0 + k);
            cyc();
        end
        load_valid = 1'b0;
        checks++; if (load_ready !== 1'b0) begin fails++; $display("FAIL ena_pending got %b exp 0", load_ready); end
        while (n < 307) cyc();
        checks++; if (col_out !== 8'h20) begin fails++; $display("FAIL ena_col5 got %h exp 20", col_out); end
        checks++; if (row_out !== 8'hC5) begin fails++; $display("FAIL ena_row5 got %h exp c5", row_out); end
        ena = 1'b0;
        cyc();
        checks++; if (col_out !== 8'h00) begin fails++; $display("FAIL ena_off_col got %h exp 00", col_out); end
        checks++; if (row_out !== 8'h00) begin fails++; $display("FAIL ena_off_row got %h exp 00", row_out); end
        checks++; if (swap_pulse !== 1'b1) begin fails++; $display("FAIL ena_swap got %b exp 1", swap_pulse); end
        checks++; if (load_ready !== 1'b1) begin fails++; $display("FAIL ena_ready got %b exp 1", load_ready); end
        repeat (3) cyc();
        checks++; if (col_out !== 8'h00) begin fails++; $display("FAIL ena_park_col got %h exp 00", col_out); end
        checks++; if (swap_pulse !== 1'b0) begin fails++; $display("FAIL ena_park_swap got %b exp 0", swap_pulse); end
        ena = 1'b1;
        cyc();
        checks++; if (frame_start !== 1'b1) begin fails++; $display("FAIL ena_fs got %b exp 1", frame_start); end
        checks++; if (col_out !== 8'h00) begin fails++; $display("FAIL ena_blank got %h exp 00", col_out); end
        while (n < 351) begin
            cyc();
            m = (n - 312) % 40;
            er = (m % 5 == 0) ? 8'h00 : 8'(8'hD0 + m / 5);
            checks++; if (col_out !== exp_col(m)) begin fails++; $display("FAIL ena_col n=%0d got %h exp %h", n, col_out, exp_col(m)); end
            checks++; if (row_out !== er) begin fails++; $display("FAIL ena_row n=%0d got %h exp %h", n, row_out, er); end
        end
    endtask

    task automatic test_reset_midload;
        for (int k = 0; k < 4; k++) begin
            load_valid = 1'b1;
            load_data = 8'(8'hE0 + k);
            cyc();
        end
        load_valid = 1'b0;
        checks++; if (col_out !== 8'h01) begin fails++; $display("FAIL pre_rst_col got %h exp 01", col_out); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (col_out !== 8'h00) begin fails++; $display("FAIL async_col got %h exp 00", col_out); end
        checks++; if (row_out !== 8'h00) begin fails++; $display("FAIL async_row got %h exp 00", row_out); end
        checks++; if (load_ready !== 1'b0) begin fails++; $display("FAIL async_ready got %b exp 0", load_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        n = -1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            checks++; if (col_out !== exp_col(n)) begin fails++; $display("FAIL rst_col n=%0d got %h exp %h", n, col_out, exp_col(n)); end
            checks++; if (row_out !== 8'h00) begin fails++; $display("FAIL rst_disp n=%0d got %h exp 00", n, row_out); end
            checks++; if (frame_start !== (n == 0)) begin fails++; $display("FAIL rst_fs n=%0d got %b exp %b", n, frame_start, n == 0); end
        end
        for (int k = 0; k < 8; k++) begin
            checks++; if (load_ready !== 1'b1) begin fails++; $display("FAIL rst_ptr k=%0d got %b exp 1", k, load_ready); end
            load_valid = 1'b1;
            load_data = 8'(8'hF0 + k);
            cyc();
        end
        load_valid = 1'b0;
        checks++; if (load_ready !== 1'b0) begin fails++; $display("FAIL rst_full got %b exp 0", load_ready); end
        while (n < 80) cyc();
        checks++; if (swap_pulse !== 1'b1) begin fails++; $display("FAIL rst_swap got %b exp 1", swap_pulse); end
        cyc();
        checks++; if (row_out !== 8'hF0) begin fails++; $display("FAIL rst_row0 got %h exp f0", row_out); end
    endtask

    task automatic test_blank0;
        logic [7:0] e;
        @(negedge clk);
        rst1_n = 1'b1;
        n = -1;
        for (int i = 0; i < 64; i++) begin
            cyc();
            e = 8'(1 << ((n % 32) / 4));
            checks++; if (col1 !== e) begin fails++; $display("FAIL nb_col n=%0d got %h exp %h", n, col1, e); end
            checks++; if (row1 !== 8'hFF) begin fails++; $display("FAIL nb_row n=%0d got %h exp ff", n, row1); end
            checks++; if (fs1 !== (n % 32 == 0)) begin fails++; $display("FAIL nb_fs n=%0d got %b exp %b", n, fs1, n % 32 == 0); end
        end
        for (int k = 0; k < 8; k++) begin
            checks++; if (rdy1 !== 1'b1) begin fails++; $display("FAIL nb_ready k=%0d got %b exp 1", k, rdy1); end
            lv1 = 1'b1;
            ld1 = 8'(1 << k);
            cyc();
        end
        lv1 = 1'b0;
        checks++; if (rdy1 !== 1'b0) begin fails++; $display("FAIL nb_full got %b exp 0", rdy1); end
        while (n < 96) cyc();
        checks++; if (sp1 !== 1'b1) begin fails++; $display("FAIL nb_swap got %b exp 1", sp1); end
        checks++; if (fs1 !== 1'b1) begin fails++; $display("FAIL nb_swap_fs got %b exp 1", fs1); end
        checks++; if (row1 !== 8'hFE) begin fails++; $display("FAIL nb_row0 got %h exp fe", row1); end
        while (n < 127) begin
            cyc();
            e = 8'(1 << ((n - 96) / 4));
            checks++; if (col1 !== e) begin fails++; $display("FAIL nb_col2 n=%0d got %h exp %h", n, col1, e); end
            checks++; if (row1 !== ~e) begin fails++; $display("FAIL nb_row2 n=%0d got %h exp %h", n, row1, ~e); end
        end
        ena1 = 1'b0;
        cyc();
        checks++; if (col1 !== 8'h00) begin fails++; $display("FAIL nb_off_col got %h exp 00", col1); end
        checks++; if (row1 !== 8'hFF) begin fails++; $display("FAIL nb_off_row got %h exp ff", row1); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_swap();
        test_restart();
        test_boundary();
        test_ena();
        test_reset_midload();
        test_blank0();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
